// File: rtl/multicycle_alu.sv
// multicycle_alu: small ALU with single-cycle logic/arith ops and an iterative
// shift-add unsigned multiplier.
//
// Ports:
//   CLK        rising-edge clock
//   RESET      synchronous, active-high reset
//   START      request an operation (taken only in IDLE or DONE)
//   SELECT     opcode: 000 fwd DATA2, 001 add, 010 and, 011 or, 100 mul,
//              101 logical shift, 110 arithmetic shift right, 111 rotate right
//   DATA1/2    operands, captured with START
//   BUSY       high while the multiplier iterates
//   DONE       one-cycle pulse, RESULT/RESULT_HI/flags valid
//   RESULT     result, or low half of the product
//   RESULT_HI  high half of the product, 0 for other ops
//   ZERO, NEGATIVE, CARRY, OVERFLOW  registered status flags
//
// An accepted START first lands in the operand registers (go_q set); the
// following edge either computes the single-cycle result into DONE or enters
// MUL. Results only change on the edge that enters DONE.

module multicycle_alu #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             ZERO,
    output logic             NEGATIVE,
    output logic             CARRY,
    output logic             OVERFLOW
);

    localparam int unsigned     CntW    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);
    localparam int unsigned     RotW    = $clog2(WIDTH);

    localparam logic [2:0] OpFwd = 3'b000;
    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpMul = 3'b100;
    localparam logic [2:0] OpLsh = 3'b101;
    localparam logic [2:0] OpAsr = 3'b110;
    localparam logic [2:0] OpRor = 3'b111;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e               state_q, state_d;
    logic                 go_q, go_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 zero_q, zero_d;
    logic                 neg_q, neg_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;

    logic                 accept;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH-1:0]     shr_amt;
    logic [RotW-1:0]      rot_amt;
    logic [RotW-1:0]      rot_rev;
    logic [WIDTH-1:0]     alu_lo;
    logic                 alu_c;
    logic                 alu_v;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    // Single-cycle datapath, fed from the captured operands.
    always_comb begin
        add_sum = {1'b0, a_q} + {1'b0, b_q};
        shr_amt = '0 - b_q;          // |DATA2| when DATA2 is negative
        rot_amt = b_q[RotW-1:0];     // DATA2 mod WIDTH
        rot_rev = '0 - rot_amt;      // WIDTH - rot_amt, wraps to 0 for no rotation
        alu_lo  = b_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OpFwd: alu_lo = b_q;
            OpAdd: begin
                alu_lo = add_sum[WIDTH-1:0];
                alu_c  = add_sum[WIDTH];
                alu_v  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OpAnd: alu_lo = a_q & b_q;
            OpOr:  alu_lo = a_q | b_q;
            OpLsh: alu_lo = b_q[WIDTH-1] ? (a_q >> shr_amt) : (a_q << b_q);
            // Shifting the inverted value keeps sign fill for any amount,
            // so amounts >= WIDTH-1 saturate to all-sign without a compare.
            OpAsr: alu_lo = a_q[WIDTH-1] ? ~(~a_q >> b_q) : (a_q >> b_q);
            OpRor: alu_lo = (a_q >> rot_amt) | (a_q << rot_rev);
            default: alu_lo = '0;
        endcase
    end

    // One shift-add step: multiplier sits in the low half and shifts out as
    // the partial product shifts in from the top.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        go_d        = 1'b0;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;

        accept = START && ((state_q == StDone) || ((state_q == StIdle) && !go_q));
        if (accept) begin
            go_d = 1'b1;
            op_d = SELECT;
            a_d  = DATA1;
            b_d  = DATA2;
        end

        case (state_q)
            StIdle: begin
                if (go_q) begin
                    if (op_q == OpMul) begin
                        state_d = StMul;
                        prod_d  = {{WIDTH{1'b0}}, b_q};
                        cnt_d   = '0;
                    end else begin
                        state_d     = StDone;
                        result_d    = alu_lo;
                        result_hi_d = '0;
                        zero_d      = (alu_lo == '0);
                        neg_d       = alu_lo[WIDTH-1];
                        carry_d     = alu_c;
                        ovf_d       = alu_v;
                    end
                end
            end
            StMul: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d     = StDone;
                    result_d    = mul_next[WIDTH-1:0];
                    result_hi_d = mul_next[2*WIDTH-1:WIDTH];
                    zero_d      = (mul_next == '0);
                    neg_d       = mul_next[2*WIDTH-1];
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            go_q        <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            go_q        <= go_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
        end
    end

    assign BUSY      = (state_q == StMul);
    assign DONE      = (state_q == StDone);
    assign RESULT    = result_q;
    assign RESULT_HI = result_hi_q;
    assign ZERO      = zero_q;
    assign NEGATIVE  = neg_q;
    assign CARRY     = carry_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=8): directed literal cases,
// an abort-by-reset case, random traffic and a continuous-START stream, all
// checked each cycle against a cycle-level reference model.

module tb_multicycle_alu;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } exp_t;

    logic         CLK;
    logic         RESET;
    logic         START;
    logic [2:0]   SELECT;
    logic [W-1:0] DATA1;
    logic [W-1:0] DATA2;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT;
    logic [W-1:0] RESULT_HI;
    logic         ZERO;
    logic         NEGATIVE;
    logic         CARRY;
    logic         OVERFLOW;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_alu #(
        .WIDTH      (W),
        .MUL_CYCLES (W)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .SELECT    (SELECT),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESULT    (RESULT),
        .RESULT_HI (RESULT_HI),
        .ZERO      (ZERO),
        .NEGATIVE  (NEGATIVE),
        .CARRY     (CARRY),
        .OVERFLOW  (OVERFLOW)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not reach its end, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic from the opcode definitions.
    function automatic exp_t ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
        exp_t r;
        int ai, bi, sa, sb, s, p, m;
        ai = int'(a);
        bi = int'(b);
        sa = (ai >= 2**(W-1)) ? ai - 2**W : ai;
        sb = (bi >= 2**(W-1)) ? bi - 2**W : bi;
        r  = '0;
        p  = 0;
        case (op)
            3'd0: r.lo = b;
            3'd1: begin
                s    = ai + bi;
                r.lo = W'(s);
                r.c  = (s >= 2**W);
                s    = sa + sb;
                r.v  = (s >= 2**(W-1)) || (s < -(2**(W-1)));
            end
            3'd2: r.lo = a & b;
            3'd3: r.lo = a | b;
            3'd4: begin
                p    = ai * bi;
                r.lo = W'(p);
                r.hi = W'(p / (2**W));
            end
            3'd5: begin
                if (sb >= 0) r.lo = (sb >= W) ? '0 : W'(ai << sb);
                else begin
                    m    = -sb;
                    r.lo = (m >= W) ? '0 : W'(ai >> m);
                end
            end
            3'd6: begin
                if (bi >= W - 1) r.lo = a[W-1] ? '1 : '0;
                else r.lo = W'(sa >>> bi);
            end
            default: begin
                m    = bi % W;
                r.lo = W'((ai >> m) | (ai << (W - m)));
            end
        endcase
        r.z = (op == 3'd4) ? (p == 0) : (r.lo == '0);
        r.n = (op == 3'd4) ? r.hi[W-1] : r.lo[W-1];
        return r;
    endfunction

    // Cycle-level model: an op accepted at edge N is in flight through its
    // completion edge (N+1, or N+W+1 for multiply); BUSY covers edges N+1..N+W.
    bit   model_valid = 0;
    bit   inflight    = 0;
    bit   is_mul      = 0;
    int   edge_i      = 0;
    int   done_edge   = 0;
    int   acc_edge    = 0;
    exp_t pend        = '0;
    exp_t exp_out     = '0;
    bit   exp_done    = 0;
    bit   exp_busy    = 0;
    int   model_done_cnt = 0;
    int   dut_done_cnt   = 0;

    initial forever begin
        bit was;
        @(posedge CLK);
        edge_i++;
        if (RESET) begin
            model_valid = 1;
            inflight    = 0;
            exp_out     = '0;
            exp_done    = 0;
            exp_busy    = 0;
        end else if (model_valid) begin
            was      = inflight;
            exp_done = 0;
            if (inflight && edge_i == done_edge) begin
                exp_out  = pend;
                exp_done = 1;
                inflight = 0;
                model_done_cnt++;
            end
            if (START && !was) begin
                pend      = ref_op(SELECT, DATA1, DATA2);
                is_mul    = (SELECT == 3'd4);
                acc_edge  = edge_i;
                done_edge = edge_i + (is_mul ? W + 1 : 1);
                inflight  = 1;
            end
            exp_busy = inflight && is_mul && (edge_i > acc_edge) && (edge_i <= acc_edge + W);
        end
    end

    initial forever begin
        @(negedge CLK);
        if (model_valid) begin
            if (DONE === 1'b1) dut_done_cnt++;
            chk("DONE", DONE, exp_done);
            chk("BUSY", BUSY, exp_busy);
            chk("RESULT", RESULT, exp_out.lo);
            chk("RESULT_HI", RESULT_HI, exp_out.hi);
            chk("ZERO", ZERO, exp_out.z);
            chk("NEGATIVE", NEGATIVE, exp_out.n);
            chk("CARRY", CARRY, exp_out.c);
            chk("OVERFLOW", OVERFLOW, exp_out.v);
        end
    end

    // Issue one op at the current negedge, scramble inputs, wait for DONE.
    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat, input logic [W-1:0] lo,
                          input logic [W-1:0] hi, input logic z, input logic n,
                          input logic c, input logic v, input bit inject);
        int k;
        int busy_n;
        SELECT = op;
        DATA1  = a;
        DATA2  = b;
        START  = 1'b1;
        @(negedge CLK);
        START  = 1'b0;
        SELECT = 3'($urandom);
        DATA1  = W'($urandom);
        DATA2  = W'($urandom);
        k      = 0;
        busy_n = 0;
        while (DONE !== 1'b1 && k < 40) begin
            if (BUSY === 1'b1) busy_n++;
            if (inject && k == 3) begin
                START  = 1'b1;
                SELECT = 3'd1;
                DATA1  = 8'h01;
                DATA2  = 8'h01;
            end else START = 1'b0;
            @(negedge CLK);
            k++;
        end
        START = 1'b0;
        chk({name, " latency"}, k, lat);
        chk({name, " busy cycles"}, busy_n, (lat > 1) ? lat - 1 : 0);
        chk({name, " done"}, DONE, 1'b1);
        chk({name, " result"}, RESULT, lo);
        chk({name, " result_hi"}, RESULT_HI, hi);
        chk({name, " flags zncv"}, {ZERO, NEGATIVE, CARRY, OVERFLOW}, {z, n, c, v});
    endtask

    initial begin
        int d0;
        int m0;
        int extra;
        RESET  = 1'b1;
        START  = 1'b0;
        SELECT = '0;
        DATA1  = '0;
        DATA2  = '0;
        repeat (3) @(negedge CLK);
        chk("reset DONE", DONE, 1'b0);
        chk("reset BUSY", BUSY, 1'b0);
        chk("reset RESULT", RESULT, 8'h00);
        RESET = 1'b0;

        //      name          op    a      b      lat lo     hi     z  n  c  v  inj
        run_op("add_7f_01",  3'd1, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 0, 1, 0, 1, 0);
        run_op("add_ff_01",  3'd1, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 1, 0, 1, 0, 0);
        run_op("mul_ff_ff",  3'd4, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 0, 1, 0, 0, 1);
        run_op("lsh_81_01",  3'd5, 8'h81, 8'h01, 1, 8'h02, 8'h00, 0, 0, 0, 0, 0);
        run_op("lsh_81_ff",  3'd5, 8'h81, 8'hFF, 1, 8'h40, 8'h00, 0, 0, 0, 0, 0);
        run_op("lsh_81_08",  3'd5, 8'h81, 8'h08, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0);
        run_op("asr_80_03",  3'd6, 8'h80, 8'h03, 1, 8'hF0, 8'h00, 0, 1, 0, 0, 0);
        run_op("asr_80_00",  3'd6, 8'h80, 8'h00, 1, 8'h80, 8'h00, 0, 1, 0, 0, 0);
        run_op("asr_40_07",  3'd6, 8'h40, 8'h07, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0);
        run_op("ror_01_09",  3'd7, 8'h01, 8'h09, 1, 8'h80, 8'h00, 0, 1, 0, 0, 0);
        run_op("and_f0_3c",  3'd2, 8'hF0, 8'h3C, 1, 8'h30, 8'h00, 0, 0, 0, 0, 0);
        run_op("or_f0_0f",   3'd3, 8'hF0, 8'h0F, 1, 8'hFF, 8'h00, 0, 1, 0, 0, 0);
        run_op("fwd_aa_00",  3'd0, 8'hAA, 8'h00, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0);
        run_op("mul_00_37",  3'd4, 8'h00, 8'h37, 9, 8'h00, 8'h00, 1, 0, 0, 0, 0);
        run_op("mul_0d_0b",  3'd4, 8'h0D, 8'h0B, 9, 8'h8F, 8'h00, 0, 0, 0, 0, 0);

        // Reset in the middle of a multiply, then an add right after.
        SELECT = 3'd4;
        DATA1  = 8'h12;
        DATA2  = 8'h34;
        START  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        chk("abort busy before reset", BUSY, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("abort DONE", DONE, 1'b0);
        chk("abort BUSY", BUSY, 1'b0);
        chk("abort outputs", {RESULT, RESULT_HI, ZERO, NEGATIVE, CARRY, OVERFLOW}, '0);
        SELECT = 3'd1;
        DATA1  = 8'h05;
        DATA2  = 8'h03;
        START  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("post-reset add pending", DONE, 1'b0);
        @(negedge CLK);
        chk("post-reset add done", DONE, 1'b1);
        chk("post-reset add result", RESULT, 8'h08);
        extra = 0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE === 1'b1) extra++;
        end
        chk("aborted mul stray DONE", extra, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            RESET  = ($urandom_range(0, 99) == 0);
            START  = 1'($urandom_range(0, 1));
            SELECT = 3'($urandom);
            DATA1  = W'($urandom);
            case ($urandom_range(0, 2))
                0:       DATA2 = W'($urandom);
                1:       DATA2 = W'($urandom_range(0, W + 1));
                default: DATA2 = W'(-int'($urandom_range(0, W + 1)));
            endcase
            @(negedge CLK);
        end
        RESET = 1'b0;
        START = 1'b0;
        repeat (W + 3) @(negedge CLK);

        // START held high through a sequence of varied ops.
        d0 = dut_done_cnt;
        m0 = model_done_cnt;
        for (int i = 0; i < 400; i++) begin
            START  = 1'b1;
            SELECT = 3'(i % 8);
            DATA1  = W'($urandom);
            DATA2  = W'($urandom);
            @(negedge CLK);
        end
        START = 1'b0;
        repeat (W + 3) @(negedge CLK);
        chk("stream done count", dut_done_cnt - d0, model_done_cnt - m0);
        chk("stream made progress", (dut_done_cnt - d0) > 50, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
